// File: rtl/bcd_step_counter_if.sv
// Request/status bundle for bcd_step_counter; master drives requests, slave is the counter.
interface bcd_step_counter_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    logic                      add;
    logic                      sub;
    logic                      clear;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic [4*NUM_DIGITS-1:0]   count;
    logic [4*NUM_DIGITS-1:0]   count_n;
    logic                      busy;
    logic                      done;
    logic                      carry_out;
    logic                      borrow_out;

    modport master (
        output add, sub, clear, load, load_val,
        input  count, count_n, busy, done, carry_out, borrow_out
    );

    modport slave (
        input  add, sub, clear, load, load_val,
        output count, count_n, busy, done, carry_out, borrow_out
    );
endinterface

// File: rtl/bcd_step_counter.sv
// Multi-digit BCD up/down counter rippling one digit per clock into a shadow register.
// BCD_SATURATE_EN: clamp to max/zero instead of wrapping when the top digit carries/borrows.
module bcd_step_counter #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned STEP       = 2,
    parameter int unsigned TOP_MOD    = 6
) (
    input  logic               clk,
    input  logic               rst,
    bcd_step_counter_if.slave  bus
);
    localparam int unsigned W = 4 * NUM_DIGITS;

`ifdef BCD_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StRipple} state_e;

    state_e         r_state, w_state_next;
    logic [W-1:0]   r_count, w_count_next;
    logic [W-1:0]   r_shadow, w_shadow_next;
    logic           r_dir, w_dir_next;           // 1 = decrement
    logic [2:0]     r_idx, w_idx_next;
    logic [3:0]     r_cin, w_cin_next;
    logic           r_done, w_done_next;
    logic           r_carry, w_carry_next;
    logic           r_borrow, w_borrow_next;

    logic [W-1:0]   w_result;
    logic [W-1:0]   w_load_clean;
    logic [W-1:0]   w_sat_max;
    logic [3:0]     w_digit;
    logic [3:0]     w_mod;
    logic [4:0]     w_tmp;
    logic           w_cout;
    logic           w_last;

    // Per-position sanitised load value and saturation ceiling.
    always_comb begin
        w_load_clean = '0;
        w_sat_max    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            int unsigned m;
            m = (i == NUM_DIGITS - 1) ? TOP_MOD : 10;
            w_load_clean[4*i +: 4] = (32'(bus.load_val[4*i +: 4]) >= m) ? 4'd0
                                                                      : bus.load_val[4*i +: 4];
            w_sat_max[4*i +: 4]    = 4'(m - 1);
        end
    end

    // Single-digit add/subtract on the digit currently selected by r_idx.
    always_comb begin
        w_digit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) w_digit = r_shadow[4*i +: 4];
        end
        w_last = (r_idx == 3'(NUM_DIGITS - 1));
        w_mod  = w_last ? 4'(TOP_MOD) : 4'd10;
        w_cout = 1'b0;
        if (!r_dir) begin
            w_tmp = {1'b0, w_digit} + {1'b0, r_cin};
            if (w_tmp >= {1'b0, w_mod}) begin
                w_tmp  = w_tmp - {1'b0, w_mod};
                w_cout = 1'b1;
            end
        end else if (w_digit < r_cin) begin
            w_tmp  = {1'b0, w_digit} + {1'b0, w_mod} - {1'b0, r_cin};
            w_cout = 1'b1;
        end else begin
            w_tmp = {1'b0, w_digit} - {1'b0, r_cin};
        end
        w_result = r_shadow;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) w_result[4*i +: 4] = w_tmp[3:0];
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_shadow_next = r_shadow;
        w_dir_next    = r_dir;
        w_idx_next    = r_idx;
        w_cin_next    = r_cin;
        w_done_next   = 1'b0;
        w_carry_next  = 1'b0;
        w_borrow_next = 1'b0;

        if (bus.clear) begin
            w_count_next = '0;
            w_state_next = StIdle;
        end else if (bus.load) begin
            w_count_next = w_load_clean;
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.add ^ bus.sub) begin
                        w_dir_next    = bus.sub;
                        w_shadow_next = r_count;
                        w_idx_next    = '0;
                        w_cin_next    = 4'(STEP);
                        w_state_next  = StRipple;
                    end
                end
                StRipple: begin
                    w_shadow_next = w_result;
                    w_idx_next    = r_idx + 3'd1;
                    w_cin_next    = {3'b000, w_cout};
                    if (w_last) begin
                        w_state_next  = StIdle;
                        w_done_next   = 1'b1;
                        w_carry_next  = w_cout & ~r_dir;
                        w_borrow_next = w_cout & r_dir;
                        w_count_next  = w_result;
                        if (SatEn && w_cout) w_count_next = r_dir ? '0 : w_sat_max;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_shadow <= '0;
            r_dir    <= 1'b0;
            r_idx    <= '0;
            r_cin    <= '0;
            r_done   <= 1'b0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_shadow <= w_shadow_next;
            r_dir    <= w_dir_next;
            r_idx    <= w_idx_next;
            r_cin    <= w_cin_next;
            r_done   <= w_done_next;
            r_carry  <= w_carry_next;
            r_borrow <= w_borrow_next;
        end
    end

    assign bus.count      = r_count;
    assign bus.count_n    = ~r_count;
    assign bus.busy       = (r_state == StRipple);
    assign bus.done       = r_done;
    assign bus.carry_out  = r_carry;
    assign bus.borrow_out = r_borrow;
endmodule

// File: tb/tb_bcd_step_counter.sv
// Bench for bcd_step_counter (2 digits, step 2, top modulus 6): vector table plus corner sequences.
module tb_bcd_step_counter;
    localparam int ND = 2;

    logic clk;
    logic rst;

    bcd_step_counter_if #(.NUM_DIGITS(ND)) bus ();

    bcd_step_counter #(
        .NUM_DIGITS (ND),
        .STEP       (2),
        .TOP_MOD    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] count;
        logic       carry;
        logic       borrow;
    } exp_t;

    typedef struct {
        logic [7:0] start;
        logic       dn;
        logic [7:0] cnt;
        logic       c;
        logic       b;
    } vec_t;

`ifdef BCD_SATURATE_EN
    localparam logic [7:0] UpWrapA = 8'h59;
    localparam logic [7:0] UpWrapB = 8'h59;
    localparam logic [7:0] DnWrapA = 8'h00;
    localparam logic [7:0] DnWrapB = 8'h00;
`else
    localparam logic [7:0] UpWrapA = 8'h00;
    localparam logic [7:0] UpWrapB = 8'h01;
    localparam logic [7:0] DnWrapA = 8'h59;
    localparam logic [7:0] DnWrapB = 8'h58;
`endif

    exp_t q[$];
    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                logic [7:0] inv;
                e   = q.pop_front();
                inv = ~bus.count;
                check("done_count", 32'(bus.count), 32'(e.count));
                check("carry_out", 32'(bus.carry_out), 32'(e.carry));
                check("borrow_out", 32'(bus.borrow_out), 32'(e.borrow));
                check("count_n", 32'(bus.count_n), 32'(inv));
            end
        end
    end

    // All tasks start and end at a falling edge.
    task automatic do_load(input logic [7:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic run_op(input logic dn, input exp_t e, input logic [7:0] start);
        int cyc;
        bus.add = ~dn;
        bus.sub = dn;
        q.push_back(e);
        @(negedge clk);
        bus.add = 1'b0;
        bus.sub = 1'b0;
        check("busy_start", 32'(bus.busy), 32'd1);
        check("count_stable", 32'(bus.count), 32'(start));
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(ND));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h58, 1'b0, UpWrapA, 1'b1, 1'b0};
        vecs[2]  = '{8'h01, 1'b1, DnWrapA, 1'b0, 1'b1};
        vecs[3]  = '{8'h08, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[4]  = '{8'h19, 1'b0, 8'h21, 1'b0, 1'b0};
        vecs[5]  = '{8'h10, 1'b1, 8'h08, 1'b0, 1'b0};
        vecs[6]  = '{8'h20, 1'b1, 8'h18, 1'b0, 1'b0};
        vecs[7]  = '{8'h57, 1'b0, 8'h59, 1'b0, 1'b0};
        vecs[8]  = '{8'h59, 1'b0, UpWrapB, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 1'b1, DnWrapB, 1'b0, 1'b1};
        vecs[10] = '{8'h35, 1'b1, 8'h33, 1'b0, 1'b0};

        rst          = 1'b1;
        bus.add      = 1'b0;
        bus.sub      = 1'b0;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(bus.count), 32'h00);
        check("rst_count_n", 32'(bus.count_n), 32'hFF);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pulses", 32'({bus.done, bus.carry_out, bus.borrow_out}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            exp_t e;
            do_load(vecs[i].start);
            e = '{vecs[i].cnt, vecs[i].c, vecs[i].b};
            run_op(vecs[i].dn, e, vecs[i].start);
        end

        // Load sanitising: out-of-range digits become zero.
        do_load(8'hA3);
        check("load_A3", 32'(bus.count), 32'h03);
        do_load(8'h7B);
        check("load_7B", 32'(bus.count), 32'h00);
        do_load(8'h59);
        check("load_59", 32'(bus.count), 32'h59);

        // add and sub together in idle are ignored.
        do_load(8'h25);
        bus.add = 1'b1;
        bus.sub = 1'b1;
        @(negedge clk);
        bus.add = 1'b0;
        bus.sub = 1'b0;
        check("both_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("both_count", 32'(bus.count), 32'h25);

        // add re-asserted while busy is dropped.
        do_load(8'h00);
        bus.add = 1'b1;
        q.push_back('{8'h02, 1'b0, 1'b0});
        @(negedge clk);
        check("retrig_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.add = 1'b0;
        repeat (5) @(negedge clk);
        check("retrig_count", 32'(bus.count), 32'h02);

        // load one cycle after accept aborts with no done.
        do_load(8'h12);
        bus.add = 1'b1;
        @(negedge clk);
        bus.add = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd1);
        do_load(8'h34);
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_count", 32'(bus.count), 32'h34);
        repeat (4) @(negedge clk);
        check("abort_hold", 32'(bus.count), 32'h34);

        // clear.
        do_load(8'h45);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear_count", 32'(bus.count), 32'h00);

        // Asynchronous reset mid-ripple.
        do_load(8'h33);
        bus.add = 1'b1;
        @(negedge clk);
        bus.add = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.count), 32'h00);
        check("arst_count_n", 32'(bus.count_n), 32'hFF);
        check("arst_busy", 32'(bus.busy), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, '{8'h02, 1'b0, 1'b0}, 8'h00);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
